// File: rtl/ucontrol_sequencer_if.sv
// Bus between the microprogram sequencer and the datapath/control store.
// The master modport is the sequencer's view. The slave modport is the
// view of the datapath and control store.
interface ucontrol_sequencer_if #(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATAWIDTH_MIR_DIRECTION = 6,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_CS_ADDRESS    = 11,
  parameter int DATAWIDTH_MICROWORD     = 41
);
  logic [DATAWIDTH_MICROWORD-1:0]     UCONTROL_MicroWord_InBus;
  logic [DATAWIDTH_BUS-1:0]           UCONTROL_IR_InBus;
  logic                               UCONTROL_SetCode_In;
  logic                               UCONTROL_FlagNegative_In;
  logic                               UCONTROL_FlagZero_In;
  logic                               UCONTROL_FlagOverflow_In;
  logic                               UCONTROL_FlagCarry_In;
  logic                               UCONTROL_MemReady_In;
  logic [DATAWIDTH_CS_ADDRESS-1:0]    UCONTROL_CSAddress_OutBus;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] UCONTROL_DirA_OutBus;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] UCONTROL_DirB_OutBus;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] UCONTROL_DirC_OutBus;
  logic                               UCONTROL_SelectA_Out;
  logic                               UCONTROL_SelectB_Out;
  logic                               UCONTROL_SelectC_Out;
  logic [DATAWIDTH_ALU_SELECTION-1:0] UCONTROL_ALUOperation_OutBus;
  logic                               UCONTROL_RD_Out;
  logic                               UCONTROL_WR_Out;
  logic                               UCONTROL_MemRequest_Out;
  logic [1:0]                         UCONTROL_State_OutBus;

  modport master (
    input  UCONTROL_MicroWord_InBus, UCONTROL_IR_InBus, UCONTROL_SetCode_In,
           UCONTROL_FlagNegative_In, UCONTROL_FlagZero_In, UCONTROL_FlagOverflow_In,
           UCONTROL_FlagCarry_In, UCONTROL_MemReady_In,
    output UCONTROL_CSAddress_OutBus, UCONTROL_DirA_OutBus, UCONTROL_DirB_OutBus,
           UCONTROL_DirC_OutBus, UCONTROL_SelectA_Out, UCONTROL_SelectB_Out,
           UCONTROL_SelectC_Out, UCONTROL_ALUOperation_OutBus, UCONTROL_RD_Out,
           UCONTROL_WR_Out, UCONTROL_MemRequest_Out, UCONTROL_State_OutBus
  );

  modport slave (
    output UCONTROL_MicroWord_InBus, UCONTROL_IR_InBus, UCONTROL_SetCode_In,
           UCONTROL_FlagNegative_In, UCONTROL_FlagZero_In, UCONTROL_FlagOverflow_In,
           UCONTROL_FlagCarry_In, UCONTROL_MemReady_In,
    input  UCONTROL_CSAddress_OutBus, UCONTROL_DirA_OutBus, UCONTROL_DirB_OutBus,
           UCONTROL_DirC_OutBus, UCONTROL_SelectA_Out, UCONTROL_SelectB_Out,
           UCONTROL_SelectC_Out, UCONTROL_ALUOperation_OutBus, UCONTROL_RD_Out,
           UCONTROL_WR_Out, UCONTROL_MemRequest_Out, UCONTROL_State_OutBus
  );
endinterface

// File: rtl/ucontrol_sequencer.sv
// Microprogrammed control unit.
// Each microinstruction is fetched into the MIR and then executed. Execution
// holds while a memory access is pending. The datapath register write, the
// memory strobes, the next-address update and the flag update all happen in
// a single commit cycle.
module ucontrol_sequencer #(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATAWIDTH_MIR_DIRECTION = 6,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_CS_ADDRESS    = 11,
  parameter int DATAWIDTH_MICROWORD     = 41,
  parameter int DATAWIDTH_COND          = 3
) (
  input logic                  UCONTROL_CLOCK_50,
  input logic                  UCONTROL_ResetInLow_In,
  ucontrol_sequencer_if.master bus
);
  typedef enum logic [1:0] {FETCH = 2'b00, EXEC = 2'b01, MEMWAIT = 2'b10} state_t;

  state_t                             state;
  logic [DATAWIDTH_CS_ADDRESS-1:0]    csar;
  logic [DATAWIDTH_MICROWORD-1:0]     mir;
  logic [3:0]                         psr;   // {N, Z, V, C}
  logic [DATAWIDTH_CS_ADDRESS-1:0]    next_addr;
  logic [DATAWIDTH_CS_ADDRESS-1:0]    csar_inc;
  logic                               commit;
  logic [DATAWIDTH_BUS-1:0]           ir;

  // Microword fields
  logic [DATAWIDTH_MIR_DIRECTION-1:0] mir_a, mir_b, mir_c;
  logic                               mir_amux, mir_bmux, mir_cmux, mir_rd, mir_wr;
  logic [DATAWIDTH_ALU_SELECTION-1:0] mir_alu;
  logic [DATAWIDTH_COND-1:0]          mir_cond;
  logic [DATAWIDTH_CS_ADDRESS-1:0]    mir_jaddr;
  logic                               mem_op;
  logic                               unused_ir;

  assign mir_a     = mir[40:35];
  assign mir_amux  = mir[34];
  assign mir_b     = mir[33:28];
  assign mir_bmux  = mir[27];
  assign mir_c     = mir[26:21];
  assign mir_cmux  = mir[20];
  assign mir_rd    = mir[19];
  assign mir_wr    = mir[18];
  assign mir_alu   = mir[17:14];
  assign mir_cond  = mir[13:11];
  assign mir_jaddr = mir[10:0];
  assign mem_op    = mir_rd | mir_wr;

  assign ir        = bus.UCONTROL_IR_InBus;
  assign unused_ir = ^{ir[29:25], ir[18:14], ir[12:0]};
  assign csar_inc  = csar + {{(DATAWIDTH_CS_ADDRESS-1){1'b0}}, 1'b1};

  // Commit when executing and no memory access is outstanding or it has just completed.
  always_comb begin
    commit = 1'b0;
    case (state)
      EXEC:    commit = !mem_op || bus.UCONTROL_MemReady_In;
      MEMWAIT: commit = bus.UCONTROL_MemReady_In;
      default: commit = 1'b0;
    endcase
  end

  // Next control store address from the branch condition and the pre-update flags.
  always_comb begin
    next_addr = csar_inc;
    case (mir_cond)
      3'd1: if (psr[3]) next_addr = mir_jaddr;
      3'd2: if (psr[2]) next_addr = mir_jaddr;
      3'd3: if (psr[1]) next_addr = mir_jaddr;
      3'd4: if (psr[0]) next_addr = mir_jaddr;
      3'd5: if (ir[13]) next_addr = mir_jaddr;
      3'd6: next_addr = mir_jaddr;
      3'd7: next_addr = {1'b1, ir[31:30], ir[24:19], 2'b00};
      default: next_addr = csar_inc;
    endcase
  end

  // Sequencer FSM together with the CSAR, MIR and PSR registers.
  always_ff @(posedge UCONTROL_CLOCK_50 or negedge UCONTROL_ResetInLow_In) begin
    if (!UCONTROL_ResetInLow_In) begin
      state <= FETCH;
      csar  <= '0;
      mir   <= '0;
      psr   <= '0;
    end else begin
      case (state)
        FETCH: begin
          mir   <= bus.UCONTROL_MicroWord_InBus;
          state <= EXEC;
        end
        EXEC, MEMWAIT: begin
          if (commit) begin
            csar  <= next_addr;
            state <= FETCH;
            if (bus.UCONTROL_SetCode_In)
              psr <= {bus.UCONTROL_FlagNegative_In, bus.UCONTROL_FlagZero_In,
                      bus.UCONTROL_FlagOverflow_In, bus.UCONTROL_FlagCarry_In};
          end else begin
            state <= MEMWAIT;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.UCONTROL_CSAddress_OutBus    = csar;
  assign bus.UCONTROL_State_OutBus        = state;
  assign bus.UCONTROL_DirA_OutBus         = mir_a;
  assign bus.UCONTROL_SelectA_Out         = mir_amux;
  assign bus.UCONTROL_DirB_OutBus         = mir_b;
  assign bus.UCONTROL_SelectB_Out         = mir_bmux;
  assign bus.UCONTROL_ALUOperation_OutBus = mir_alu;
  // Outside commit cycles the C write is steered to r0 so that it is discarded.
  assign bus.UCONTROL_DirC_OutBus         = commit ? mir_c : '0;
  assign bus.UCONTROL_SelectC_Out         = commit & mir_cmux;
  assign bus.UCONTROL_RD_Out              = commit & mir_rd;
  assign bus.UCONTROL_WR_Out              = commit & mir_wr;
  assign bus.UCONTROL_MemRequest_Out      = (state == EXEC || state == MEMWAIT) & mem_op;
endmodule

// File: tb/tb_ucontrol_sequencer.sv
// Bench for ucontrol_sequencer: a random control store is driven at the
// microinstruction level. Each datapath-visible output is compared with a
// model that knows only the address rules and the fetch/execute/commit timing.
module tb_ucontrol_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ucontrol_sequencer_if ifc();
  ucontrol_sequencer dut (
    .UCONTROL_CLOCK_50     (clk),
    .UCONTROL_ResetInLow_In(rst_n),
    .bus                   (ifc)
  );

  logic [40:0] rom [0:2047];
  assign ifc.UCONTROL_MicroWord_InBus = rom[ifc.UCONTROL_CSAddress_OutBus];

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_pc;
  logic [40:0] m_mir;
  logic        m_n, m_z, m_v, m_c;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] mk(input logic [5:0] a, input logic amux, input logic [5:0] b,
                                     input logic bmux, input logic [5:0] c, input logic cmux,
                                     input logic rd, input logic wr, input logic [3:0] alu,
                                     input logic [2:0] cond, input logic [10:0] jaddr);
    return {a, amux, b, bmux, c, cmux, rd, wr, alu, cond, jaddr};
  endfunction

  function automatic logic [40:0] rnd_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[40:0];
  endfunction

  function automatic int model_next(input int pc, input logic [40:0] w, input logic [31:0] ir);
    int  cond;
    int  j;
    bit  take;
    cond = int'(w[13:11]);
    j    = int'(w[10:0]);
    take = 1'b0;
    case (cond)
      1: take = m_n;
      2: take = m_z;
      3: take = m_v;
      4: take = m_c;
      5: take = ir[13];
      6: take = 1'b1;
      7: return 1024 + int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4;
      default: take = 1'b0;
    endcase
    return take ? j : (pc + 1) % 2048;
  endfunction

  task automatic drive(input logic rdy, input logic sc, input logic [3:0] fl, input logic [31:0] ir);
    ifc.UCONTROL_MemReady_In     = rdy;
    ifc.UCONTROL_SetCode_In      = sc;
    ifc.UCONTROL_FlagNegative_In = fl[3];
    ifc.UCONTROL_FlagZero_In     = fl[2];
    ifc.UCONTROL_FlagOverflow_In = fl[1];
    ifc.UCONTROL_FlagCarry_In    = fl[0];
    ifc.UCONTROL_IR_InBus        = ir;
  endtask

  task automatic check_outs(input logic [40:0] w, input bit commit, input logic [1:0] st,
                            input bit memreq);
    chk("state",  ifc.UCONTROL_State_OutBus, st);
    chk("csaddr", ifc.UCONTROL_CSAddress_OutBus, m_pc);
    chk("dira",   ifc.UCONTROL_DirA_OutBus, w[40:35]);
    chk("sela",   ifc.UCONTROL_SelectA_Out, w[34]);
    chk("dirb",   ifc.UCONTROL_DirB_OutBus, w[33:28]);
    chk("selb",   ifc.UCONTROL_SelectB_Out, w[27]);
    chk("alu",    ifc.UCONTROL_ALUOperation_OutBus, w[17:14]);
    chk("dirc",   ifc.UCONTROL_DirC_OutBus, commit ? w[26:21] : 6'd0);
    chk("selc",   ifc.UCONTROL_SelectC_Out, commit ? w[20] : 1'b0);
    chk("rd",     ifc.UCONTROL_RD_Out, commit ? w[19] : 1'b0);
    chk("wr",     ifc.UCONTROL_WR_Out, commit ? w[18] : 1'b0);
    chk("memreq", ifc.UCONTROL_MemRequest_Out, memreq);
  endtask

  // One fetch cycle: MemReady, SetCode and the flags are random here and must not matter.
  task automatic fetch_cycle();
    drive(1'($urandom), 1'($urandom), 4'($urandom), $urandom);
    #1;
    check_outs(m_mir, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    m_mir = rom[m_pc];
  endtask

  // Execute the fetched microinstruction. A memory op waits 'waits' cycles before it completes.
  task automatic exec_instr(input int waits, input logic sc, input logic [3:0] fl,
                            input logic [31:0] ir);
    bit mem;
    int n;
    int nxt;
    mem = m_mir[19] | m_mir[18];
    n   = mem ? waits : 0;
    for (int i = 0; i <= n; i++) begin
      bit last;
      last = (i == n);
      if (last) drive(mem ? 1'b1 : 1'($urandom), sc, fl, ir);
      else      drive(1'b0, 1'($urandom), 4'($urandom), $urandom);
      #1;
      check_outs(m_mir, last, (i == 0) ? 2'b01 : 2'b10, mem);
      nxt = model_next(m_pc, m_mir, ir);
      @(posedge clk); #1;
      if (last) begin
        m_pc = nxt;
        if (sc) {m_n, m_z, m_v, m_c} = fl;
      end
    end
  endtask

  task automatic run_instr(input int waits, input logic sc, input logic [3:0] fl,
                           input logic [31:0] ir);
    fetch_cycle();
    exec_instr(waits, sc, fl, ir);
  endtask

  task automatic clear_model();
    m_pc  = 0;
    m_mir = '0;
    {m_n, m_z, m_v, m_c} = 4'b0000;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = rnd_word();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 32'd0);
    clear_model();
    @(posedge clk); #1;
    check_outs('0, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain register op: C=5 is written in the EXEC cycle only.
    rom[0] = mk(6'd1, 1'b0, 6'd2, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 4'b0011, 3'b000, 11'h7ff);
    run_instr(0, 1'b0, 4'b0000, 32'd0);
    chk("seq_inc", ifc.UCONTROL_CSAddress_OutBus, 11'd1);

    // Set Z, then branch on Z.
    rom[1] = mk(6'd3, 1'b0, 6'd4, 1'b0, 6'd6, 1'b0, 1'b0, 1'b0, 4'b0001, 3'b000, 11'h000);
    run_instr(0, 1'b1, 4'b0100, 32'd0);
    rom[2] = mk(6'd7, 1'b1, 6'd8, 1'b0, 6'd9, 1'b1, 1'b0, 1'b0, 4'b0010, 3'b010, 11'h123);
    run_instr(0, 1'b0, 4'b0000, 32'd0);
    chk("bz_taken", ifc.UCONTROL_CSAddress_OutBus, 11'h123);

    // Clear Z, then the same branch falls through.
    rom[11'h123] = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd10, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 11'h000);
    run_instr(0, 1'b1, 4'b0000, 32'd0);
    rom[11'h124] = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd11, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b010, 11'h077);
    run_instr(0, 1'b0, 4'b1011, 32'd0);
    chk("bz_not_taken", ifc.UCONTROL_CSAddress_OutBus, 11'h125);

    // Jump to the top address, then wrap.
    rom[11'h125] = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b110, 11'h7ff);
    run_instr(0, 1'b0, 4'b0000, 32'd0);
    rom[11'h7ff] = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd12, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 11'h055);
    run_instr(0, 1'b0, 4'b0000, 32'd0);
    chk("wrap", ifc.UCONTROL_CSAddress_OutBus, 11'd0);

    // Decode: IR[31:30]=10, IR[24:19]=0 gives {1,10,000000,00}.
    rom[0] = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b111, 11'h000);
    run_instr(0, 1'b0, 4'b0000, 32'h8A00_0000);
    chk("decode", ifc.UCONTROL_CSAddress_OutBus, 11'h600);

    // Memory read to r3 with three wait cycles.
    rom[11'h600] = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd3, 1'b0, 1'b1, 1'b0, 4'b0000, 3'b000, 11'h000);
    run_instr(3, 1'b0, 4'b0000, 32'd0);

    // Random microprograms.
    for (int k = 0; k < 300; k++)
      run_instr($urandom_range(0, 3), 1'($urandom), 4'($urandom), $urandom);

    // Set every flag, then reset in the middle of a memory write.
    rom[m_pc] = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 11'h000);
    run_instr(0, 1'b1, 4'b1111, 32'd0);
    rom[m_pc] = mk(6'd2, 1'b0, 6'd3, 1'b0, 6'd4, 1'b0, 1'b0, 1'b1, 4'b0101, 3'b000, 11'h000);
    fetch_cycle();
    drive(1'b0, 1'b0, 4'b0000, 32'd0);
    #1;
    check_outs(m_mir, 1'b0, 2'b01, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'b0000, 32'd0);
    #1;
    check_outs(m_mir, 1'b0, 2'b10, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_outs('0, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Flags were cleared by reset, so a branch on Z falls through.
    rom[0] = mk(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b010, 11'h300);
    run_instr(0, 1'b0, 4'b0000, 32'd0);
    chk("psr_cleared", ifc.UCONTROL_CSAddress_OutBus, 11'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
